// File: rtl/keypad_scanner_if.sv
// Key-event bundle from keypad_scanner to the consuming fabric.
interface keypad_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    modport master (output key_code, key_valid, key_held, multi_key);
    modport slave  (input  key_code, key_valid, key_held, multi_key);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-level press/release debounce.
// Define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every REPEAT_FRAMES while a key is held.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_FRAMES  = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row_n,
    output logic [3:0]       col_n,
    keypad_scanner_if.master key_bus
);
    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned DebW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
    localparam logic [DebW-1:0] DebTarget = DebW'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_FRAMES < 1) begin : g_bad_params
        $error("keypad_scanner: invalid parameters");
    end

    typedef enum logic [1:0] {StIdle, StDebounce, StPressed} state_e;

    logic [3:0]      row_meta_q, row_sync_q;
    logic [DivW-1:0] div_cnt_q;
    logic [1:0]      col_idx_q;
    logic [1:0]      acc_cnt_q;
    logic [3:0]      acc_code_q;
    state_e          state_q;
    logic [3:0]      cand_q;
    logic [DebW-1:0] cnt_q, rel_cnt_q;
    logic [3:0]      key_code_q;
    logic            key_valid_q, key_held_q, multi_key_q;

    logic [3:0] rows;
    logic       sample, frame_end, frame_one, accept;
    logic [2:0] col_keys, sum;
    logic [1:0] col_row, frame_cnt;
    logic [3:0] frame_code;

    assign rows      = ~row_sync_q;
    assign col_n     = ~(4'b0001 << col_idx_q);
    assign sample    = (div_cnt_q == DivLast);
    assign frame_end = sample && (col_idx_q == 2'd3);

    // Fold the current column into the frame accumulators; saturate the key count at 2.
    always_comb begin
        col_keys = 3'd0;
        col_row  = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            col_keys = col_keys + {2'b00, rows[r]};
            if (rows[r]) col_row = 2'(r);
        end
        sum        = {1'b0, acc_cnt_q} + col_keys;
        frame_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        frame_code = (acc_cnt_q == 2'd0) ? {col_row, col_idx_q} : acc_code_q;
    end

    assign frame_one = (frame_cnt == 2'd1);
    assign accept    = frame_end && frame_one &&
                       ((state_q == StIdle && DEBOUNCE_SCANS == 1) ||
                        (state_q == StDebounce && frame_code == cand_q &&
                         cnt_q + 1'b1 == DebTarget));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
            div_cnt_q  <= '0;
            col_idx_q  <= '0;
            acc_cnt_q  <= '0;
            acc_code_q <= '0;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
            if (sample) begin
                div_cnt_q <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                if (col_idx_q == 2'd3) begin
                    acc_cnt_q  <= '0;
                    acc_code_q <= '0;
                end else begin
                    acc_cnt_q  <= frame_cnt;
                    acc_code_q <= frame_code;
                end
            end else begin
                div_cnt_q <= div_cnt_q + 1'b1;
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RepW-1:0] RepTarget = RepW'(REPEAT_FRAMES);
    logic [RepW-1:0] rep_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cand_q      <= '0;
            cnt_q       <= '0;
            rel_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_key_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            if (frame_end) begin
                multi_key_q <= (frame_cnt == 2'd2);
                if (accept) begin
                    state_q     <= StPressed;
                    key_code_q  <= frame_code;
                    key_valid_q <= 1'b1;
                    key_held_q  <= 1'b1;
                    rel_cnt_q   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_cnt_q   <= '0;
`endif
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            if (frame_one) begin
                                state_q <= StDebounce;
                                cand_q  <= frame_code;
                                cnt_q   <= DebW'(1);
                            end
                        end
                        StDebounce: begin
                            if (frame_one) begin
                                // A different single key restarts the count on that key.
                                cand_q <= frame_code;
                                cnt_q  <= (frame_code == cand_q) ? cnt_q + 1'b1 : DebW'(1);
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                        StPressed: begin
                            if (frame_cnt == 2'd0) begin
                                if (rel_cnt_q + 1'b1 == DebTarget) begin
                                    state_q    <= StIdle;
                                    key_held_q <= 1'b0;
                                    rel_cnt_q  <= '0;
                                end else begin
                                    rel_cnt_q <= rel_cnt_q + 1'b1;
                                end
                            end else begin
                                rel_cnt_q <= '0;
                            end
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (frame_one && frame_code == key_code_q) begin
                                if (rep_cnt_q + 1'b1 == RepTarget) begin
                                    rep_cnt_q   <= '0;
                                    key_valid_q <= 1'b1;
                                end else begin
                                    rep_cnt_q <= rep_cnt_q + 1'b1;
                                end
                            end else begin
                                rep_cnt_q <= '0;
                            end
`endif
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

    assign key_bus.key_code  = key_code_q;
    assign key_bus.key_valid = key_valid_q;
    assign key_bus.key_held  = key_held_q;
    assign key_bus.multi_key = multi_key_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench: frame-aligned random key sets, expectations from a frame-history model.
module tb_keypad_scanner;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 2;
    localparam int unsigned REP      = 3;
    localparam int FRAME = 4 * SCAN_DIV;
    localparam int NONE  = -1;
    localparam int MULTI = -2;

    typedef struct { int cyc; int code; } pulse_t;
    typedef struct { int cyc; int code; bit held; bit multi; } stat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row_n, col_n;
    logic [15:0] pressed = '0;

    keypad_scanner_if key_bus ();

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_FRAMES(REP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row_n(row_n),
        .col_n(col_n),
        .key_bus(key_bus)
    );

    always #5 clk = ~clk;

    // Diode matrix: a row reads low when a pressed key sits on the driven column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    pulse_t pulse_q[$];
    stat_t  stat_q[$];
    int     hist[$];
    bit     m_held = 1'b0;
    int     m_code = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
    int     m_rep = 0;
`endif

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    endtask

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    pulse_t     mon_p;
    stat_t      mon_s;
    logic [3:0] mon_col;

    always @(negedge clk) begin
        if (rst_n) begin
            mon_col = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
            check("col_n", int'(col_n), int'(mon_col));
            while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
                mon_p = pulse_q.pop_front();
                check("missed_key_valid_cycle", cyc, mon_p.cyc);
            end
            if (key_bus.key_valid) begin
                if (pulse_q.size() == 0) begin
                    check("unexpected_key_valid", int'(key_bus.key_valid), 0);
                end else begin
                    mon_p = pulse_q.pop_front();
                    check("key_valid_cycle", cyc, mon_p.cyc);
                    check("key_valid_code", int'(key_bus.key_code), mon_p.code);
                end
            end
            while (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
                mon_s = stat_q.pop_front();
                check("status_cycle", cyc, mon_s.cyc);
                check("key_held", int'(key_bus.key_held), int'(mon_s.held));
                check("multi_key", int'(key_bus.multi_key), int'(mon_s.multi));
                check("key_code", int'(key_bus.key_code), mon_s.code);
            end
        end
    end

    function automatic int frame_result(input logic [15:0] keys);
        int n = 0;
        int code = NONE;
        for (int k = 0; k < 16; k++) begin
            if (keys[k]) begin
                n++;
                code = k;
            end
        end
        if (n == 0) return NONE;
        if (n > 1) return MULTI;
        return code;
    endfunction

    function automatic bit window_all(input int v);
        if (hist.size() != int'(DEB)) return 1'b0;
        foreach (hist[i]) if (hist[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    // Accept when the last DEB frames since the last state change are one identical key;
    // release when the last DEB frames while held are all empty.
    task automatic model_frame(input int r, input int end_cyc);
        bit pulse = 1'b0;
        hist.push_back(r);
        if (hist.size() > int'(DEB)) void'(hist.pop_front());
        if (!m_held) begin
            if (r >= 0 && window_all(r)) begin
                pulse  = 1'b1;
                m_held = 1'b1;
                m_code = r;
                hist.delete();
`ifdef KEYPAD_AUTOREPEAT_EN
                m_rep = 0;
`endif
            end
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            if (r == m_code) begin
                m_rep++;
                if (m_rep == int'(REP)) begin
                    pulse = 1'b1;
                    m_rep = 0;
                end
            end else begin
                m_rep = 0;
            end
`endif
            if (r == NONE && window_all(NONE)) begin
                m_held = 1'b0;
                hist.delete();
            end
        end
        if (pulse) pulse_q.push_back('{cyc: end_cyc, code: m_code});
        stat_q.push_back('{cyc: end_cyc, code: m_code, held: m_held, multi: (r == MULTI)});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at the first cycle of a frame; the key set stays constant for the whole frame.
    task automatic run_frame(input logic [15:0] keys);
        int f;
        pressed = keys;
        f = cyc / FRAME;
        model_frame(frame_result(keys), (f + 1) * FRAME);
        wait_cycles(FRAME);
    endtask

    task automatic do_reset(input int n);
        pulse_q.delete();
        stat_q.delete();
        hist.delete();
        m_held = 1'b0;
        m_code = 0;
        rst_n  = 1'b0;
        wait_cycles(n);
        @(negedge clk);
        check("reset_col_n", int'(col_n), 14);
        check("reset_key_code", int'(key_bus.key_code), 0);
        check("reset_key_valid", int'(key_bus.key_valid), 0);
        check("reset_key_held", int'(key_bus.key_held), 0);
        check("reset_multi_key", int'(key_bus.multi_key), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cur;
        int a, b, sel;
        do_reset(3);
        // Single press of key 6, hold, release.
        repeat (3) run_frame(16'h0040);
        repeat (2) run_frame(16'h0000);
        // Bounce on key 6.
        run_frame(16'h0040);
        run_frame(16'h0000);
        run_frame(16'h0040);
        run_frame(16'h0000);
        run_frame(16'h0000);
        // Chord 0+5, then release 5.
        repeat (3) run_frame(16'h0021);
        repeat (3) run_frame(16'h0001);
        repeat (2) run_frame(16'h0000);
        // Reset in the second frame of a press on key 6, key kept down.
        run_frame(16'h0040);
        wait_cycles(FRAME / 2);
        do_reset(3);
        repeat (5) run_frame(16'h0040);
        repeat (2) run_frame(16'h0000);
        // Randomised frames.
        cur = '0;
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 99) >= 55) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 3) begin
                    cur = '0;
                end else if (sel < 9) begin
                    cur = 16'd1 << $urandom_range(0, 15);
                end else begin
                    a   = int'($urandom_range(0, 15));
                    b   = (a + 1 + int'($urandom_range(0, 14))) % 16;
                    cur = (16'd1 << a) | (16'd1 << b);
                end
            end
            run_frame(cur);
        end
        pressed = '0;
        wait_cycles(2 * FRAME);
        check("pulses_outstanding", pulse_q.size(), 0);
        check("status_outstanding", stat_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
